med_line_buffer: RTL and testbench
==================================

MED_LINE_BUFFER -- requirements
Module: med_line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, maximum pixels per line; line-memory depth.
REQ-003 SHALL have parameter WINDOW_SIZE, default 3, window height; only 3 supported.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  pixel qualifier; no backpressure.
REQ-007 in_data  input  DATA_WIDTH  pixel, raster order.
REQ-008 in_sof  input  1  first pixel of frame; ignored unless in_valid.
REQ-009 in_eol  input  1  last pixel of line; ignored unless in_valid.
REQ-010 out_valid  output  1  column valid.
REQ-011 w1 / w2 / w3  output  DATA_WIDTH each  pixel at current column from rows y-2 / y-1 / y.
REQ-012 out_sol, out_eol  output  1 each  first / last column of output line.
REQ-013 line_err  output  1  one-cycle pulse on line overrun.

Function
REQ-014 Two line memories of IMG_WIDTH x DATA_WIDTH SHALL hold rows y-1 (L0) and y-2 (L1).
REQ-015 On accepted pixel at column x: read L0[x], L1[x]; write L0[x]<=in_data, L1[x]<=old L0[x] (read-before-write, same cycle).
REQ-016 Outputs SHALL be registered, latency exactly 1 cycle: w3=in_data, w2=old L0[x], w1=old L1[x].
REQ-017 col_cnt SHALL increment per accepted pixel; reset to 0 after in_eol pixel.
REQ-018 row_cnt SHALL increment after each in_eol pixel, saturating at 2.
REQ-019 out_valid SHALL be asserted 1 cycle after an accepted pixel iff row_cnt==2 at acceptance; rows 0 and 1 of every frame produce no output.
REQ-020 out_sol SHALL be 1 with out_valid when source col_cnt==0; out_eol with out_valid when source pixel ended the line (in_eol or overrun).
REQ-021 in_sof with in_valid SHALL force that pixel to col 0, row 0 regardless of prior counters (mid-frame restart); subsequent counting continues from it.
REQ-022 in_sof and in_eol on same pixel: pixel is a 1-pixel row 0; next pixel is row 1, col 0.
REQ-023 col_cnt reaching IMG_WIDTH-1 without in_eol: pixel SHALL be treated as line end (col wraps to 0, row_cnt increments), line_err pulses 1 cycle with the output.
REQ-024 in_valid low: no counter, memory or row change; out_valid 0 next cycle; w1..w3 hold last values.
REQ-025 Lines shorter than IMG_WIDTH SHALL be supported; columns beyond line length are not read.

Reset
REQ-026 On rst: col_cnt=0, row_cnt=0, out_valid=0, out_sol=0, out_eol=0, line_err=0, w1=w2=w3=0.
REQ-027 rst mid-line SHALL discard the partial frame; next accepted pixel is row 0, col 0; memories not cleared (gated by row_cnt).
REQ-028 rst SHALL dominate in_valid in the same cycle; that pixel is dropped.

Structure
REQ-029 Shared package med_pkg SHALL hold DATA_WIDTH/IMG_WIDTH defaults, pixel_t typedef, and column-address width constant ($clog2(IMG_WIDTH)).
REQ-030 One sub-module med_line_ram (single-port, read-before-write, registered read, one write enable) SHALL be instantiated twice for L0 and L1.
REQ-031 Outputs w1,w2,w3,out_valid SHALL connect directly to the 3-input row comparator downstream with no added latency.

Verification
REQ-032 IMG_WIDTH=4, 4 rows, pixel=16*row+col, continuous valid -> out_valid only for rows 2,3 (8 cycles); row 2 col 1: w1=0x01, w2=0x11, w3=0x21; out_sol on col 0, out_eol on col 3.
REQ-033 Same frame with in_valid low every other cycle -> identical output sequence, out_valid 0 in gap cycles, w1..w3 held.
REQ-034 in_sof at row 3 col 2 -> no output for that pixel nor for the following two lines; first output on third new row, w1 from new row 0.
REQ-035 IMG_WIDTH=4, 6 pixels without in_eol -> line_err pulse with 4th pixel output cycle, 5th pixel counted as col 0 of next row.
REQ-036 rst asserted at row 2 col 2 -> all outputs 0 next cycle; restart frame needs 2 full rows before out_valid.
REQ-037 1-pixel lines (in_sof+in_eol, then in_eol each pixel) values 5,6,7 -> single output w1=5, w2=6, w3=7, out_sol=out_eol=1.

Source files
------------

// File: rtl/med_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : med_pkg
//  Description : Shared defaults, pixel type, column-address helper and the
//                row-fill state encoding for the median line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package med_pkg;

    localparam int c_data_width  = 8;
    localparam int c_img_width   = 640;
    localparam int c_window_size = 3;

    // Column address width; a 1-deep line still needs one address bit
    function automatic int col_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int c_col_width = col_addr_width(c_img_width);

    typedef logic [c_data_width-1:0] pixel_t;

    // How many complete rows of the current frame are already stored
    typedef enum logic [1:0] {
        ROW_FIRST  = 2'd0,
        ROW_SECOND = 2'd1,
        ROW_ACTIVE = 2'd2
    } row_state_t;

endpackage
`default_nettype wire

// File: rtl/med_line_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : med_line_buffer_if
//  Description : Pixel input stream and 3-row column output of the median
//                line buffer. master = pixel source/consumer, slave = buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface med_line_buffer_if
    import med_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic                  in_eol;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] w1;
    logic [DATA_WIDTH-1:0] w2;
    logic [DATA_WIDTH-1:0] w3;
    logic                  out_sol;
    logic                  out_eol;
    logic                  line_err;

    modport master (
        output in_valid, in_data, in_sof, in_eol,
        input  out_valid, w1, w2, w3, out_sol, out_eol, line_err
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_eol,
        output out_valid, w1, w2, w3, out_sol, out_eol, line_err
    );
endinterface
`default_nettype wire

// File: rtl/med_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : med_line_ram
//  Description : Single-port line memory, read-before-write, registered read
//                data. Read data only updates on an enabled access so it holds
//                across idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module med_line_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_en,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    output      logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Registered read returning the pre-write content of the addressed word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    // Array write kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/med_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : med_line_buffer
//  Description : 3-row line buffer feeding a column-wise median comparator.
//                Each accepted pixel produces, one cycle later, the pixels at
//                the same column from rows y-2 (w1), y-1 (w2) and y (w3).
//  Revision    : 1.0 - initial release
// ============================================================================
module med_line_buffer
    import med_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width,
    parameter int IMG_WIDTH   = c_img_width,
    parameter int WINDOW_SIZE = c_window_size
) (
    input wire logic          clk,
    input wire logic          rst,
    med_line_buffer_if.slave  bus
);

    localparam int              c_aw       = col_addr_width(IMG_WIDTH);
    localparam logic [c_aw-1:0] c_last_col = c_aw'(IMG_WIDTH - 1);

    // Only a 3-row window is implemented
    if (WINDOW_SIZE != 3) begin : g_window_unsupported
        $error("med_line_buffer: WINDOW_SIZE must be 3");
    end

    logic                  w_accept;
    logic [c_aw-1:0]       w_col_eff;
    row_state_t            w_row_eff;
    logic                  w_at_last;
    logic                  w_overrun;
    logic                  w_line_end;

    row_state_t            r_row;
    row_state_t            w_row_next;
    logic [c_aw-1:0]       r_col;
    logic [c_aw-1:0]       w_col_next;
    logic                  r_wr_bank;
    logic                  w_wr_bank_next;
    logic                  r_rd_sel;

    logic                  r_out_valid;
    logic                  r_out_sol;
    logic                  r_out_eol;
    logic                  r_line_err;
    logic [DATA_WIDTH-1:0] r_w3;
    logic [DATA_WIDTH-1:0] w_rd [2];

    // Reset wins over a pixel offered in the same cycle
    assign w_accept = bus.in_valid && !rst;

    // Position of the current pixel: in_sof restarts the frame at row 0, col 0
    always_comb begin
        w_col_eff  = bus.in_sof ? '0 : r_col;
        w_row_eff  = bus.in_sof ? ROW_FIRST : r_row;
        w_at_last  = (w_col_eff == c_last_col);
        w_overrun  = w_at_last && !bus.in_eol;
        w_line_end = bus.in_eol || w_at_last;
    end

    // Next column, row-fill state and write-bank selection
    always_comb begin
        w_row_next     = r_row;
        w_col_next     = r_col;
        w_wr_bank_next = r_wr_bank;
        if (w_accept) begin
            w_row_next = w_row_eff;
            w_col_next = w_line_end ? '0 : w_col_eff + 1'b1;
            if (w_line_end) begin
                w_wr_bank_next = !r_wr_bank;
                case (w_row_eff)
                    ROW_FIRST:  w_row_next = ROW_SECOND;
                    ROW_SECOND: w_row_next = ROW_ACTIVE;
                    default:    w_row_next = ROW_ACTIVE;
                endcase
            end
        end
    end

    // Counter and row-state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= ROW_FIRST;
            r_col     <= '0;
            r_wr_bank <= 1'b0;
        end else begin
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_wr_bank <= w_wr_bank_next;
        end
    end

    // Registered output strobes, current-row pixel and bank-order capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sol   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_line_err  <= 1'b0;
            r_w3        <= '0;
            r_rd_sel    <= 1'b0;
        end else begin
            r_out_valid <= w_accept && (w_row_eff == ROW_ACTIVE);
            r_out_sol   <= w_accept && (w_row_eff == ROW_ACTIVE) && (w_col_eff == '0);
            r_out_eol   <= w_accept && (w_row_eff == ROW_ACTIVE) && w_line_end;
            r_line_err  <= w_accept && w_overrun;
            if (w_accept) begin
                r_w3     <= bus.in_data;
                r_rd_sel <= r_wr_bank;
            end
        end
    end

    // Two banks play the y-1 and y-2 roles. The bank holding y-2 is read and
    // overwritten with row y in the same access; at each line end the roles
    // swap, which moves y-1 into the y-2 slot without copying any data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        med_line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .ADDR_WIDTH (c_aw)
        ) u_ram (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_accept),
            .i_we      (w_accept && (r_wr_bank == 1'(gi))),
            .i_addr    (w_col_eff),
            .i_wr_data (bus.in_data),
            .o_rd_data (w_rd[gi])
        );
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sol   = r_out_sol;
    assign bus.out_eol   = r_out_eol;
    assign bus.line_err  = r_line_err;
    assign bus.w3        = r_w3;
    assign bus.w1        = w_rd[r_rd_sel];
    assign bus.w2        = w_rd[!r_rd_sel];

endmodule
`default_nettype wire

// File: tb/tb_med_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_med_line_buffer
//  Description : Self-checking bench for med_line_buffer (IMG_WIDTH = 4).
//                A frame-history model predicts every output column.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_med_line_buffer;
    import med_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    med_line_buffer_if #(.DATA_WIDTH(8)) bus();

    med_line_buffer #(
        .DATA_WIDTH  (8),
        .IMG_WIDTH   (W),
        .WINDOW_SIZE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: every pixel of the frame indexed by (row since sof, column)
    pixel_t     hist [int];
    int         m_row = 0;
    int         m_col = 0;
    logic [3:0] e_ctl;      // {out_valid, out_sol, out_eol, line_err}
    pixel_t     e_w1, e_w2, e_w3;
    logic       e_wk;       // w1/w2 expectation is defined

    // Drive one cycle of stimulus and advance the model's expectations
    task automatic step(input logic v, input pixel_t d, input logic s,
                        input logic e, input logic r);
        logic le, er;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sof   = s;
        bus.in_eol   = e;
        if (r) begin
            m_row = 0; m_col = 0;
            e_ctl = '0; e_w1 = '0; e_w2 = '0; e_w3 = '0; e_wk = 1'b1;
        end else if (v) begin
            if (s) begin m_row = 0; m_col = 0; end
            le    = e || (m_col == W - 1);
            er    = !e && (m_col == W - 1);
            e_ctl = {m_row >= 2, (m_row >= 2) && (m_col == 0), (m_row >= 2) && le, er};
            e_w3  = d;
            if (m_row >= 2) begin
                e_w1 = hist[(m_row - 2) * W + m_col];
                e_w2 = hist[(m_row - 1) * W + m_col];
                e_wk = 1'b1;
            end else begin
                e_wk = 1'b0;
            end
            hist[m_row * W + m_col] = d;
            if (le) begin m_row++; m_col = 0; end
            else m_col++;
        end else begin
            e_ctl = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);   // pixel offered during reset is dropped
        n_checks++;
        if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w1, bus.w2, bus.w3} !== 28'h0) begin
            n_errors++;
            $display("FAIL reset outputs got %h expected 0",
                     {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w1, bus.w2, bus.w3});
        end
    endtask

    task automatic test_full_frame();
        int n_ov = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, pixel_t'(16 * r + c), (r == 0) && (c == 0), c == W - 1, 1'b0);
                n_checks++;
                if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                    n_errors++;
                    $display("FAIL full_frame ctl/w3 got %h expected %h",
                             {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
                end
                if (e_wk) begin
                    n_checks++;
                    if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                        n_errors++;
                        $display("FAIL full_frame w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                    end
                end
                if (r == 2 && c == 1) begin
                    n_checks++;
                    if ({bus.w1, bus.w2, bus.w3} !== 24'h011121) begin
                        n_errors++;
                        $display("FAIL full_frame r2c1 window got %h expected 011121", {bus.w1, bus.w2, bus.w3});
                    end
                end
                if (bus.out_valid) n_ov++;
            end
        end
        n_checks++;
        if (n_ov !== 8) begin
            n_errors++;
            $display("FAIL full_frame out_valid count got %0d expected 8", n_ov);
        end
    endtask

    task automatic test_gapped();
        int n_ov = 0;
        for (int p = 0; p < 2 * 4 * W; p++) begin
            int r = p / (2 * W);
            int c = (p / 2) % W;
            if (p % 2 == 0)
                step(1'b1, pixel_t'(16 * r + c), (r == 0) && (c == 0), c == W - 1, 1'b0);
            else    // idle cycle with junk on the qualified-only inputs
                step(1'b0, pixel_t'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                n_errors++;
                $display("FAIL gapped ctl/w3 got %h expected %h",
                         {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
            end
            if (e_wk) begin
                n_checks++;
                if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                    n_errors++;
                    $display("FAIL gapped w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                end
            end
            if (bus.out_valid) n_ov++;
        end
        n_checks++;
        if (n_ov !== 8) begin
            n_errors++;
            $display("FAIL gapped out_valid count got %0d expected 8", n_ov);
        end
    endtask

    task automatic test_restart();
        int     n_ov_early = 0;
        pixel_t first_new  = '0;
        // Old frame up to row 3 col 1, then a new frame starting at old row 3 col 2
        for (int p = 0; p < 14 + 4 * W; p++) begin
            logic   s, e;
            pixel_t d = pixel_t'($urandom);
            if (p < 14) begin
                s = (p == 0);
                e = (p % W) == W - 1;
            end else begin
                s = (p == 14);
                e = ((p - 14) % W) == W - 1;
                if (p == 14) first_new = d;
            end
            step(1'b1, d, s, e, 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                n_errors++;
                $display("FAIL restart ctl/w3 got %h expected %h",
                         {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
            end
            if (e_wk) begin
                n_checks++;
                if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                    n_errors++;
                    $display("FAIL restart w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                end
            end
            if (p >= 14 && p < 14 + 2 * W && bus.out_valid) n_ov_early++;
            if (p == 14 + 2 * W) begin
                n_checks++;
                if ({bus.out_valid, bus.w1} !== {1'b1, first_new}) begin
                    n_errors++;
                    $display("FAIL restart first_output got %h expected %h", {bus.out_valid, bus.w1}, {1'b1, first_new});
                end
            end
        end
        n_checks++;
        if (n_ov_early !== 0) begin
            n_errors++;
            $display("FAIL restart early_outputs got %0d expected 0", n_ov_early);
        end
    endtask

    task automatic test_overrun();
        int     n_err_pulse = 0;
        pixel_t fifth       = '0;
        // 6 pixels without eol, then finish row 1 and run one full row 2
        for (int p = 0; p < 6 + 2 + W; p++) begin
            pixel_t d = pixel_t'($urandom);
            logic   e = (p == 7) || (p == 7 + W);
            if (p == 4) fifth = d;
            step(1'b1, d, p == 0, e, 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                n_errors++;
                $display("FAIL overrun ctl/w3 got %h expected %h",
                         {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
            end
            if (e_wk) begin
                n_checks++;
                if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                    n_errors++;
                    $display("FAIL overrun w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                end
            end
            if (bus.line_err) n_err_pulse++;
            if (p == 3) begin
                n_checks++;
                if (bus.line_err !== 1'b1) begin
                    n_errors++;
                    $display("FAIL overrun line_err_4th got %b expected 1", bus.line_err);
                end
            end
            if (p == 8) begin
                n_checks++;
                if ({bus.out_sol, bus.w2} !== {1'b1, fifth}) begin
                    n_errors++;
                    $display("FAIL overrun fifth_is_col0 got %h expected %h", {bus.out_sol, bus.w2}, {1'b1, fifth});
                end
            end
        end
        n_checks++;
        if (n_err_pulse !== 1) begin
            n_errors++;
            $display("FAIL overrun pulse_count got %0d expected 1", n_err_pulse);
        end
    endtask

    task automatic test_reset_mid();
        int n_ov = 0;
        for (int p = 0; p < 2 * W + 3; p++) begin
            step(1'b1, pixel_t'($urandom), p == 0, (p % W) == W - 1, 1'b0);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid pre_reset_valid got %b expected 1", bus.out_valid);
        end
        step(1'b1, pixel_t'($urandom), 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w1, bus.w2, bus.w3} !== 28'h0) begin
            n_errors++;
            $display("FAIL reset_mid outputs got %h expected 0",
                     {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w1, bus.w2, bus.w3});
        end
        // Restart without in_sof: two full rows before any output
        for (int p = 0; p < 3 * W; p++) begin
            step(1'b1, pixel_t'($urandom), 1'b0, (p % W) == W - 1, 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                n_errors++;
                $display("FAIL reset_mid ctl/w3 got %h expected %h",
                         {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
            end
            if (e_wk) begin
                n_checks++;
                if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                    n_errors++;
                    $display("FAIL reset_mid w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                end
            end
            if (p < 2 * W && bus.out_valid) n_ov++;
        end
        n_checks++;
        if (n_ov !== 0) begin
            n_errors++;
            $display("FAIL reset_mid early_outputs got %0d expected 0", n_ov);
        end
    endtask

    task automatic test_one_pixel();
        pixel_t vals [3] = '{8'h05, 8'h06, 8'h07};
        for (int p = 0; p < 3; p++) begin
            step(1'b1, vals[p], p == 0, 1'b1, 1'b0);
            n_checks++;
            if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                n_errors++;
                $display("FAIL one_pixel ctl/w3 got %h expected %h",
                         {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
            end
        end
        n_checks++;
        if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.w1, bus.w2, bus.w3} !== {3'b111, 24'h050607}) begin
            n_errors++;
            $display("FAIL one_pixel window got %h expected %h",
                     {bus.out_valid, bus.out_sol, bus.out_eol, bus.w1, bus.w2, bus.w3}, {3'b111, 24'h050607});
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int len  = $urandom_range(1, W);
            bit ovr  = (len == W) && ($urandom_range(0, 1) == 1);
            int rows = $urandom_range(1, 5);
            int stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rows * len) : rows * len;
            for (int p = 0; p < stop; p++) begin
                int gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                int c    = p % len;
                for (int k = 0; k <= gaps; k++) begin
                    if (k < gaps)
                        step(1'b0, pixel_t'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                    else
                        step(1'b1, pixel_t'($urandom), p == 0, (c == len - 1) && !ovr, 1'b0);
                    n_checks++;
                    if ({bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3} !== {e_ctl, e_w3}) begin
                        n_errors++;
                        $display("FAIL random ctl/w3 got %h expected %h",
                                 {bus.out_valid, bus.out_sol, bus.out_eol, bus.line_err, bus.w3}, {e_ctl, e_w3});
                    end
                    if (e_wk) begin
                        n_checks++;
                        if ({bus.w1, bus.w2} !== {e_w1, e_w2}) begin
                            n_errors++;
                            $display("FAIL random w1/w2 got %h expected %h", {bus.w1, bus.w2}, {e_w1, e_w2});
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
        test_reset();
        test_full_frame();
        test_gapped();
        test_restart();
        test_overrun();
        test_reset_mid();
        test_one_pixel();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
